// File: rtl/fir_decimator.sv
// 31-tap triangle-window FIR with 8:1 decimation. A delay line shifts on every valid_in,
// and on each trigger a snapshot is taken and multiply-accumulated one tap per cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a trigger sample (decimation counter at DECIM-1)
// S_MAC  | r_tap 0..NUM_TAPS-1 accumulates taps, r_tap == NUM_TAPS publishes
module fir_decimator #(
    parameter int NUM_TAPS = 31,
    parameter int DECIM    = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic signed [7:0] audio_in,
    input  logic              valid_in,
    output logic signed [7:0] filtered_audio,
    output logic              data_ready
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TAP_W = $clog2(NUM_TAPS + 1);
    localparam int ACC_W = 20;
    localparam int PRD_W = 14;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MAC  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [7:0]       r_dline [NUM_TAPS];
    logic signed [7:0]       r_snap  [NUM_TAPS];
    logic [CNT_W-1:0]        r_dcnt;
    logic [TAP_W-1:0]        r_tap;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_trigger;
    logic                    w_start;
    logic                    w_last;
    logic [4:0]              w_coef;
    logic signed [PRD_W-1:0] w_prod;

    // Triangle window h[k] = min(k+1, NUM_TAPS-k); sums to 256 for 31 taps.
    function automatic logic [4:0] coef(input int k);
        int a;
        int b;
        a = k + 1;
        b = NUM_TAPS - k;
        if (b < 0) begin
            b = 0;
        end
        return (a < b) ? 5'(a) : 5'(b);
    endfunction

    assign w_trigger = valid_in && (r_dcnt == CNT_W'(DECIM - 1));
    assign w_last    = (r_tap == TAP_W'(NUM_TAPS));
    assign w_coef    = coef(int'(r_tap));
    assign w_prod    = PRD_W'(r_snap[0]) * PRD_W'($signed({1'b0, w_coef}));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_start      = 1'b1;
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dcnt <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_dline[i] <= '0;
            end
        end else if (valid_in) begin
            r_dcnt     <= w_trigger ? '0 : r_dcnt + CNT_W'(1);
            r_dline[0] <= audio_in;
            for (int i = 1; i < NUM_TAPS; i++) begin
                r_dline[i] <= r_dline[i-1];
            end
        end
    end

    // The snapshot drains toward index 0 so the MAC always reads r_snap[0].
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_start) begin
            r_snap[0] <= audio_in;
            for (int i = 1; i < NUM_TAPS; i++) begin
                r_snap[i] <= r_dline[i-1];
            end
        end else if (r_state == S_MAC && !w_last) begin
            for (int i = 0; i < NUM_TAPS - 1; i++) begin
                r_snap[i] <= r_snap[i+1];
            end
            r_snap[NUM_TAPS-1] <= '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tap          <= '0;
            r_acc          <= '0;
            filtered_audio <= '0;
            data_ready     <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            if (w_start) begin
                r_tap <= '0;
                r_acc <= '0;
            end else if (r_state == S_MAC) begin
                if (w_last) begin
                    filtered_audio <= 8'(r_acc >>> 8);
                    data_ready     <= 1'b1;
                end else begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_tap <= r_tap + TAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Randomized and directed bench for fir_decimator; an arithmetic reference model
// feeds a time-stamped scoreboard that a negedge monitor drains on data_ready.
module tb_fir_decimator;

    localparam int NT  = 31;
    localparam int DEC = 8;
    localparam int LAT = 32;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic signed [7:0] audio_in = '0;
    logic              valid_in = 1'b0;
    logic signed [7:0] filtered_audio;
    logic              data_ready;

    fir_decimator #(.NUM_TAPS(NT), .DECIM(DEC)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (audio_in),
        .valid_in       (valid_in),
        .filtered_audio (filtered_audio),
        .data_ready     (data_ready)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] seen[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         win[NT];
    int         n_samp = 0;
    bit         lenient = 1'b0;
    logic [7:0] held = '0;
    int         dr_count = 0;
    int         last_dr = -1000;
    bit         prev_dr = 1'b0;

    always @(posedge clk_in) cyc++;

    // Reference: plain convolution of the newest NT samples with the triangle window.
    function automatic logic [7:0] model_out();
        int acc;
        int y;
        int h;
        acc = 0;
        for (int k = 0; k < NT; k++) begin
            h = (k + 1 < NT - k) ? k + 1 : NT - k;
            acc += win[k] * h;
        end
        y = acc >>> 8;
        return y[7:0];
    endfunction

    task automatic send(input logic [7:0] s, input int gap);
        exp_t e;
        for (int k = NT - 1; k > 0; k--) win[k] = win[k-1];
        win[0] = int'($signed(s));
        if (n_samp % DEC == DEC - 1) begin
            e.cyc = cyc + 1 + LAT;
            e.val = model_out();
            sb.push_back(e);
        end
        n_samp++;
        audio_in = s;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (gap - 1) @(negedge clk_in);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h want 0x%02h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        check8("reset_out", filtered_audio, 8'h00);
        check8("reset_ready", {7'd0, data_ready}, 8'h00);
        sb.delete();
        seen.delete();
        held = '0;
        n_samp = 0;
        for (int k = 0; k < NT; k++) win[k] = 0;
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic drain();
        repeat (LAT + 8) @(negedge clk_in);
        if (lenient) begin
            sb.delete();
        end else begin
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d outputs still pending, want 0", sb.size());
            end
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in) begin
            prev_dr = 1'b0;
            last_dr = -1000;
        end else begin
            if (data_ready) begin
                dr_count++;
                seen.push_back(filtered_audio);
                checks++;
                if (prev_dr) begin
                    errors++;
                    $display("FAIL ready_width: data_ready high 2 cycles at cyc %0d, want 1", cyc);
                end
                checks++;
                if (cyc - last_dr < LAT) begin
                    errors++;
                    $display("FAIL ready_spacing: %0d cycles apart, want >= %0d", cyc - last_dr, LAT);
                end
                last_dr = cyc;
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    if (!lenient) begin
                        checks++;
                        errors++;
                        $display("FAIL missing: no output at cyc %0d, want 0x%02h", sb[0].cyc, sb[0].val);
                    end
                    void'(sb.pop_front());
                end
                checks++;
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    held = e.val;
                    if (filtered_audio !== e.val) begin
                        errors++;
                        $display("FAIL output: got 0x%02h want 0x%02h at cyc %0d", filtered_audio, e.val, cyc);
                    end
                end else begin
                    errors++;
                    $display("FAIL unexpected: data_ready at cyc %0d with 0x%02h, want none", cyc, filtered_audio);
                end
            end else begin
                checks++;
                if (filtered_audio !== held) begin
                    errors++;
                    $display("FAIL hold: got 0x%02h want 0x%02h at cyc %0d", filtered_audio, held, cyc);
                end
            end
            prev_dr = data_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        for (int k = 0; k < NT; k++) win[k] = 0;
        do_reset();

        // DC at full negative-one level
        for (int i = 0; i < 64; i++) send(8'hFF, 16);
        drain();
        check8("dc_ff_count", 8'(seen.size()), 8'd8);
        for (int i = 3; i < seen.size(); i++) check8("dc_ff_value", seen[i], 8'hFF);

        do_reset();
        for (int i = 0; i < 48; i++) send(8'h80, 16);
        drain();
        check8("dc_80_count", 8'(seen.size()), 8'd6);
        if (seen.size() > 0) check8("dc_80_value", seen[seen.size()-1], 8'h80);

        do_reset();
        for (int i = 0; i < 32; i++) send(8'h00, 16);
        drain();
        check8("zero_count", 8'(seen.size()), 8'd4);
        for (int i = 0; i < seen.size(); i++) check8("zero_value", seen[i], 8'h00);

        do_reset();
        send(8'h7F, 16);
        for (int i = 1; i < 32; i++) send(8'h00, 16);
        drain();
        check8("imp_count", 8'(seen.size()), 8'd4);
        if (seen.size() == 4) begin
            check8("imp_s7", seen[0], 8'h03);
            check8("imp_s15", seen[1], 8'h07);
            check8("imp_s23", seen[2], 8'h03);
            check8("imp_s31", seen[3], 8'h00);
        end

        do_reset();
        for (int i = 0; i < 96; i++) send(8'($urandom_range(0, 255)), int'($urandom_range(16, 20)));
        drain();

        // Back-to-back samples: triggers during MAC are dropped
        lenient = 1'b1;
        base = dr_count;
        for (int i = 0; i < 120; i++) send(8'($urandom_range(0, 255)), 1);
        drain();
        lenient = 1'b0;
        checks++;
        if (dr_count - base < 3) begin
            errors++;
            $display("FAIL busy_outputs: got %0d outputs, want >= 3", dr_count - base);
        end

        // Reset 10 cycles after a trigger aborts that output
        do_reset();
        for (int i = 0; i < 7; i++) send(8'h7F, 16);
        send(8'h7F, 1);
        repeat (9) @(negedge clk_in);
        base = dr_count;
        do_reset();
        repeat (LAT + 8) @(negedge clk_in);
        check8("abort_no_ready", 8'(dr_count - base), 8'd0);
        check8("abort_out", filtered_audio, 8'h00);

        // No output until DECIM fresh samples after reset
        for (int i = 0; i < 7; i++) send(8'h40, 16);
        check8("post_reset_quiet", 8'(dr_count - base), 8'd0);
        send(8'h40, 16);
        drain();
        check8("post_reset_one", 8'(dr_count - base), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
